// File: rtl/cflog_writer_if.sv
// Bundle between the CFA log monitor, the CFLog writer and the data memory port.
// Optional ovf_irq member exists only when CFLOG_OVF_IRQ_EN is defined.
interface cflog_writer_if;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic        hw_wr_en;
  logic [15:0] cflow_log_ptr;
  logic        flush;
  logic        mem_busy;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        fifo_empty;
  logic        overflow;
  logic        log_committed;
`ifdef CFLOG_OVF_IRQ_EN
  logic        ovf_irq;
`endif

  modport slave (
    input  pc, pc_nxt, hw_wr_en, cflow_log_ptr, flush, mem_busy,
    output mem_wr_en, mem_addr, mem_wdata, fifo_empty, overflow, log_committed
`ifdef CFLOG_OVF_IRQ_EN
    , output ovf_irq
`endif
  );

  modport master (
    output pc, pc_nxt, hw_wr_en, cflow_log_ptr, flush, mem_busy,
    input  mem_wr_en, mem_addr, mem_wdata, fifo_empty, overflow, log_committed
`ifdef CFLOG_OVF_IRQ_EN
    , input ovf_irq
`endif
  );
endinterface

// File: rtl/cflog_writer.sv
// Buffers monitor log requests in a small FIFO and drains them to a shared single-port memory.
// Define CFLOG_OVF_IRQ_EN to add a one-shot ovf_irq pulse on the first dropped entry.
module cflog_writer #(
  parameter logic [15:0] LOG_BASE   = 16'h0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PTR_W      = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  cflog_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [15:0]    r_pc_nxt_d;
  logic [15:0]    r_fifo_addr [FIFO_DEPTH];
  logic [15:0]    r_fifo_data [FIFO_DEPTH];
  logic [PTR_W:0] r_wptr;
  logic [PTR_W:0] r_rptr;
  logic [15:0]    r_mem_addr;
  logic [15:0]    r_mem_wdata;
  logic           r_overflow;
  logic           r_log_committed;

  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [15:0]    w_entry_addr;
  logic [15:0]    w_head_addr;
  logic [15:0]    w_head_data;
  logic           w_unused_pc;

  assign w_unused_pc = ^bus.pc;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign w_pop  = (r_state == ST_ISSUE) && !bus.mem_busy;
  assign w_push = bus.hw_wr_en && (!w_full || w_pop);
  assign w_drop = bus.hw_wr_en && w_full && !w_pop;

  assign w_entry_addr = LOG_BASE + ((bus.cflow_log_ptr == 16'h0000) ? 16'h0000
                                                                     : (bus.cflow_log_ptr - 16'd2));
  assign w_head_addr  = r_fifo_addr[r_rptr[PTR_W-1:0]];
  assign w_head_data  = r_fifo_data[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[PTR_W-1:0]] <= w_entry_addr;
      r_fifo_data[r_wptr[PTR_W-1:0]] <= r_pc_nxt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pc_nxt_d <= 16'h0000;
    end else begin
      r_pc_nxt_d <= bus.pc_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (!bus.mem_busy) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The address/data registers remember the last committed write so the bus holds between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr      <= 16'h0000;
      r_mem_wdata     <= 16'h0000;
      r_overflow      <= 1'b0;
      r_log_committed <= 1'b0;
    end else begin
      if (w_pop) begin
        r_mem_addr  <= w_head_addr;
        r_mem_wdata <= w_head_data;
      end
      if (w_drop) r_overflow <= 1'b1;
      r_log_committed <= bus.flush && w_empty && (r_state == ST_IDLE);
    end
  end

  assign bus.mem_wr_en     = w_pop;
  assign bus.mem_addr      = (r_state == ST_ISSUE) ? w_head_addr : r_mem_addr;
  assign bus.mem_wdata     = (r_state == ST_ISSUE) ? w_head_data : r_mem_wdata;
  assign bus.fifo_empty    = w_empty;
  assign bus.overflow      = r_overflow;
  assign bus.log_committed = r_log_committed;

`ifdef CFLOG_OVF_IRQ_EN
  logic r_ovf_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ovf_irq <= 1'b0;
    else          r_ovf_irq <= w_drop && !r_overflow;
  end

  assign bus.ovf_irq = r_ovf_irq;
`endif

  a_log_base_even: assert property (@(posedge clk) LOG_BASE[0] == 1'b0)
    else $error("cflog_writer: LOG_BASE must be even");

endmodule

// File: tb/tb_cflog_writer.sv
// Scoreboard bench for cflog_writer: a cycle-indexed stimulus table is scored by a spec-level
// model (write-time rule plus occupancy counting) and checked by an independent monitor.
module tb_cflog_writer;
  localparam logic [15:0] LOG_BASE = 16'h6000;
  localparam int DEPTH = 4;
  localparam int N     = 460;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  cflog_writer_if bus();

  cflog_writer #(.LOG_BASE(LOG_BASE), .FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t expQ[$];
  int  nChecks = 0;
  int  nPass   = 0;

  logic        reqA   [N];
  logic        busyA  [N];
  logic        flushA [N];
  logic [15:0] ptrA   [N];
  logic [15:0] pcnA   [N];
  int          wcyc   [N];
  logic        writeAt[N];
  logic        expEmpty[N];
  logic        expOvf [N];
  logic        expIrq [N];
  logic        expComm[N];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  function automatic logic [15:0] slotAddr(input logic [15:0] ptr);
    logic [15:0] off;
    off = (ptr == 16'h0000) ? 16'h0000 : ptr - 16'd2;
    return LOG_BASE + off;
  endfunction

  // Directed scenarios first, then a random region, then a quiet tail that hosts the flush case.
  task automatic buildStimulus();
    for (int c = 0; c < N; c++) begin
      reqA[c] = 1'b0; busyA[c] = 1'b0; flushA[c] = 1'b0;
      ptrA[c] = 16'h0000; pcnA[c] = 16'($urandom_range(0, 65535));
    end
    pcnA[3] = 16'hE0A4; reqA[4] = 1'b1; ptrA[4] = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      reqA[10 + i] = 1'b1; ptrA[10 + i] = 16'(2 * (i + 1));
    end
    reqA[20] = 1'b1; ptrA[20] = 16'h0008;
    for (int c = 22; c <= 26; c++) busyA[c] = 1'b1;
    reqA[30] = 1'b1; ptrA[30] = 16'h0000;
    reqA[32] = 1'b1; ptrA[32] = 16'h000A;
    reqA[34] = 1'b1; ptrA[34] = 16'h000A;
    reqA[36] = 1'b1; ptrA[36] = 16'hA002;
    for (int c = 50; c <= 69; c++) busyA[c] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reqA[50 + 2 * i] = 1'b1; ptrA[50 + 2 * i] = 16'(16'h0020 + 2 * i);
    end
    reqA[62] = 1'b1; ptrA[62] = 16'h0030;
    reqA[70] = 1'b1; ptrA[70] = 16'h0040;
    for (int c = 100; c < 380; c++) begin
      reqA[c]   = ($urandom_range(0, 99) < 50);
      busyA[c]  = ($urandom_range(0, 99) < 30);
      flushA[c] = ($urandom_range(0, 99) < 15);
      ptrA[c]   = 16'($urandom_range(0, 65535)) & 16'hFFFE;
    end
    for (int c = 405; c <= 430; c++) flushA[c] = 1'b1;
    reqA[410] = 1'b1; ptrA[410] = 16'h0100;
    reqA[411] = 1'b1; ptrA[411] = 16'h0102;
  endtask

  // An entry is written at the first non-busy cycle at least two cycles after its request
  // and two cycles after the previous write; it occupies the buffer from the cycle after
  // its request through its write cycle.
  task automatic computeModel();
    int lastW;
    int firstDrop;
    int occ;
    int t;
    logic pop;
    lastW = -10;
    firstDrop = -1;
    for (int c = 0; c < N; c++) begin
      wcyc[c] = -1; writeAt[c] = 1'b0;
    end
    for (int c = 0; c < N; c++) begin
      occ = 0; pop = 1'b0;
      for (int k = 0; k < c; k++) begin
        if (wcyc[k] >= c) occ++;
        if (wcyc[k] == c) pop = 1'b1;
      end
      expEmpty[c] = (occ == 0);
      if (reqA[c]) begin
        if (occ < DEPTH || pop) begin
          t = (c + 2 > lastW + 2) ? c + 2 : lastW + 2;
          while (t < N - 1 && busyA[t]) t++;
          wcyc[c] = t; lastW = t; writeAt[t] = 1'b1;
        end else if (firstDrop < 0) begin
          firstDrop = c;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      expOvf[c]  = (firstDrop >= 0) && (c > firstDrop);
      expIrq[c]  = (firstDrop >= 0) && (c == firstDrop + 1);
      expComm[c] = (c >= 2) ? (flushA[c-1] && expEmpty[c-1] && !writeAt[c-2]) : 1'b0;
    end
  endtask

  task automatic applyStimulus(input int c);
    wr_t e;
    bus.hw_wr_en      = reqA[c];
    bus.cflow_log_ptr = ptrA[c];
    bus.pc_nxt        = pcnA[c];
    bus.pc            = pcnA[c] - 16'd2;
    bus.mem_busy      = busyA[c];
    bus.flush         = flushA[c];
    if (reqA[c] && wcyc[c] >= 0 && c >= 1) begin
      e.cyc = wcyc[c]; e.addr = slotAddr(ptrA[c]); e.data = pcnA[c-1];
      expQ.push_back(e);
    end
  endtask

  task automatic monitorCycle(input int c);
    wr_t e;
    checkOutput("fifo_empty", bus.fifo_empty, expEmpty[c]);
    checkOutput("overflow", bus.overflow, expOvf[c]);
    checkOutput("log_committed", bus.log_committed, expComm[c]);
`ifdef CFLOG_OVF_IRQ_EN
    checkOutput("ovf_irq", bus.ovf_irq, expIrq[c]);
`endif
    if (bus.mem_wr_en) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_write", bus.mem_wr_en, 1'b0);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_cycle", c, e.cyc);
        checkOutput("write_addr", bus.mem_addr, e.addr);
        checkOutput("write_data", bus.mem_wdata, e.data);
      end
    end else if (expQ.size() > 0 && expQ[0].cyc <= c) begin
      e = expQ.pop_front();
      checkOutput("missed_write", bus.mem_wr_en, 1'b1);
    end
  endtask

  initial begin
    int stray;
    bus.hw_wr_en = 1'b0; bus.cflow_log_ptr = 16'h0000; bus.pc_nxt = 16'h0000;
    bus.pc = 16'h0000; bus.mem_busy = 1'b0; bus.flush = 1'b0;
    resetN = 1'b0;
    buildStimulus();
    computeModel();

    #21;
    checkOutput("reset_mem_wr_en", bus.mem_wr_en, 1'b0);
    checkOutput("reset_mem_addr", bus.mem_addr, 16'h0000);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 16'h0000);
    checkOutput("reset_fifo_empty", bus.fifo_empty, 1'b1);
    checkOutput("reset_overflow", bus.overflow, 1'b0);
    checkOutput("reset_log_committed", bus.log_committed, 1'b0);
    #2 resetN = 1'b1;

    fork
      begin
        for (int c = 0; c < N; c++) begin
          @(negedge clk);
          applyStimulus(c);
        end
      end
      begin
        for (int c = 0; c < N; c++) begin
          @(negedge clk);
          #1;
          monitorCycle(c);
        end
      end
    join
    checkOutput("pending_writes", expQ.size(), 0);

    // Reset while an entry is being presented: the strobe must drop immediately and the entry must vanish.
    @(negedge clk);
    bus.hw_wr_en = 1'b1; bus.cflow_log_ptr = 16'h0020; bus.mem_busy = 1'b1; bus.flush = 1'b0;
    @(negedge clk);
    bus.hw_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    bus.mem_busy = 1'b0;
    #1 checkOutput("strobe_before_reset", bus.mem_wr_en, 1'b1);
    #1 resetN = 1'b0;
    #1;
    checkOutput("async_reset_wr_en", bus.mem_wr_en, 1'b0);
    checkOutput("async_reset_fifo_empty", bus.fifo_empty, 1'b1);
    checkOutput("async_reset_overflow", bus.overflow, 1'b0);
    checkOutput("async_reset_mem_addr", bus.mem_addr, 16'h0000);
    @(negedge clk);
    #3 resetN = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      #1 if (bus.mem_wr_en) stray++;
    end
    checkOutput("stray_write_after_reset", stray, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
